tile_result_collector: RTL and testbench
========================================

Name: tile_result_collector

Overview:
- Output-side counterpart to the tile broadcast stage: accepts the TILE_SIZE x TILE_SIZE result tile from the PE array and converts it to the form the downstream writeback needs.
- MAC mode (3'b000): reduces each row to a scalar and accumulates over a programmable number of K-tiles, then emits one vector.
- Element-wise and outer modes (3'b001-3'b110): buffer the tile and stream it out row by row.
- Valid/ready handshakes on both sides.

Parameters:
- TILE_SIZE, 4, array dimension.
- DATA_WIDTH, 16, signed width of each PE result element.
- ACC_WIDTH, 32, signed width of accumulators and output elements.
- KT_W, 8, width of the K-tile count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  3  operation mode; same encoding as the broadcast stage.
- k_tiles  in  KT_W  number of tiles to accumulate in MAC mode; 0 is treated as 1.
- in_valid  in  1  in_tile valid.
- in_ready  out  1  collector can accept a tile.
- in_tile  in  TILE_SIZE*TILE_SIZE*DATA_WIDTH  signed [TILE_SIZE][TILE_SIZE][DATA_WIDTH] array result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  TILE_SIZE*ACC_WIDTH  signed [TILE_SIZE][ACC_WIDTH].
- out_row_idx  out  $clog2(TILE_SIZE)  row index of the current beat; 0 for a MAC vector.
- out_is_vec  out  1  1 = reduced MAC vector, 0 = tile row.
- err  out  1  one-cycle pulse when a tile is accepted with mode 3'b111.

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset rst_n.
- Reset values:
  - state = IDLE; accumulators and tile buffer = 0; counters = 0.
  - out_valid = 0, out_data = 0, out_row_idx = 0, out_is_vec = 0, err = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all partial sums and buffered rows.
- A handshake occurs when valid and ready are both high on a rising edge.
- States: IDLE, ACCUM, EMIT.
- in_ready:
  - 1 in IDLE and ACCUM, 0 in EMIT.
  - No same-cycle bypass from EMIT to a new acceptance.
- IDLE, tile accepted:
  - mode and k_tiles are latched. Later changes to these inputs are ignored until the operation returns to IDLE.
  - mode 000:
    - acc[i] is loaded with rowsum(i), not added to old contents. rowsum(i) = sum over j of sign-extended in_tile[i][j].
    - kcnt = 1.
    - If the effective k equals 1, go to EMIT; otherwise go to ACCUM.
  - modes 001-110: the tile is captured into the buffer; row counter = 0; go to EMIT.
  - mode 111: the tile is dropped; err = 1 for exactly the next cycle; stay in IDLE.
- ACCUM:
  - Each accepted tile: acc[i] += rowsum(i) and kcnt++.
  - When kcnt reaches the effective k, go to EMIT.
  - Arithmetic is two's-complement at ACC_WIDTH, wrap on overflow, no saturation.
- EMIT, MAC:
  - One beat: out_data[i] = acc[i], out_is_vec = 1, out_row_idx = 0.
  - On out_ready, go to IDLE.
- EMIT, tile modes:
  - TILE_SIZE beats. Beat r: out_data[j] = sign-extended buf[r][j], out_row_idx = r, out_is_vec = 0.
  - The row advances on each handshake.
  - After the handshake of row TILE_SIZE-1, go to IDLE.
- Latency: out_valid rises the cycle after the final input handshake (1 cycle).
- Output stability: out_valid, out_data, out_row_idx and out_is_vec are held stable while out_valid=1 and out_ready=0.
- out_valid drops the cycle after the last beat's handshake, unless a new operation has already completed. It cannot have, because in_ready=0 during EMIT.
- in_valid while in_ready=0: no effect; the upstream must hold the tile.
- Registered outputs: out_* and err are driven from flops. in_ready is combinational from state only.

Test Plan:
1. MAC, k_tiles=1, in_tile[i][j]=i+1, out_ready=1 -> one beat one cycle after accept: out_data={4,8,12,16}, out_is_vec=1, out_row_idx=0; in_ready=0 during that beat, then 1.
2. MAC, k_tiles=3, tiles all 1, then all 2, then all -3; in_valid gaps between tiles -> single beat out_data={0,0,0,0}; no out_valid before the third acceptance. Repeat with k_tiles=0 and all -32768 -> out_data all -131072 (treated as k=1). Repeat with k_tiles=2, all -32768 -> -262144 per row.
3. Mode 001, in_tile[i][j]=10*i+j, out_ready pattern 1,0,0,1,1,0,1 -> 4 beats: row r = {10r, 10r+1, 10r+2, 10r+3}, out_row_idx 0..3, data held stable during stalls, in_ready=0 until the cycle after the row-3 handshake.
4. Mode change mid-ACCUM: MAC with k_tiles=2, mode switched to 010 before tile 2 -> tile 2 still row-summed; output is one MAC vector.
5. Mode 111 with in_valid=1 -> err=1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1; a following mode-011 tile streams normally.
6. Reset: assert rst_n=0 during EMIT of mode 010 after 2 rows -> next cycle out_valid=0, in_ready=1. Then MAC k=1 with all-1 tile -> out_data={4,4,4,4} (no stale sums).

Source files
------------

// File: rtl/tile_result_collector.sv
// rtl/tile_result_collector.sv - collects PE-array result tiles into MAC vectors or row streams
module tile_result_collector #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int KT_W       = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [2:0]                              mode,
  input  logic [KT_W-1:0]                         k_tiles,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [TILE_SIZE*TILE_SIZE*DATA_WIDTH-1:0] in_tile,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [TILE_SIZE*ACC_WIDTH-1:0]          out_data,
  output logic [$clog2(TILE_SIZE)-1:0]            out_row_idx,
  output logic                                    out_is_vec,
  output logic                                    err
);
  localparam int RW = $clog2(TILE_SIZE);
  localparam int TW = TILE_SIZE * TILE_SIZE * DATA_WIDTH;
  localparam int VW = TILE_SIZE * ACC_WIDTH;
  localparam logic [2:0] MODE_MAC = 3'b000;
  localparam logic [2:0] MODE_BAD = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, EMIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      mode_q;
  logic [KT_W-1:0] ktgt_q, kcnt_q, k_eff;
  logic [VW-1:0]   acc_q, rowsum_v, accsum_v;
  logic [TW-1:0]   buf_q;
  logic [RW-1:0]   row_q;
  logic            accept, out_fire, last_row, mac_done, emit_done;

  logic            out_valid_d, out_is_vec_d, err_d;
  logic [VW-1:0]   out_data_d;
  logic [RW-1:0]   out_row_idx_d;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] d);
    return {{(ACC_WIDTH-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
  endfunction

  function automatic logic [ACC_WIDTH-1:0] row_sum(input logic [TW-1:0] t, input int r);
    logic [ACC_WIDTH-1:0] s;
    s = '0;
    for (int j = 0; j < TILE_SIZE; j++)
      s = s + sext(t[(r*TILE_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]);
    return s;
  endfunction

  function automatic logic [VW-1:0] tile_row(input logic [TW-1:0] t, input logic [RW-1:0] r);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < TILE_SIZE; j++)
      v[j*ACC_WIDTH +: ACC_WIDTH] = sext(t[(int'(r)*TILE_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]);
    return v;
  endfunction

  // Row sums wrap at ACC_WIDTH; the accumulate path reuses them for every K-tile.
  always_comb begin
    rowsum_v = '0;
    accsum_v = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      rowsum_v[i*ACC_WIDTH +: ACC_WIDTH] = row_sum(in_tile, i);
      accsum_v[i*ACC_WIDTH +: ACC_WIDTH] = acc_q[i*ACC_WIDTH +: ACC_WIDTH] + row_sum(in_tile, i);
    end
  end

  assign in_ready  = (state_q != EMIT);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign k_eff     = (k_tiles == '0) ? KT_W'(1) : k_tiles;
  assign last_row  = (row_q == RW'(TILE_SIZE-1));
  assign mac_done  = ((kcnt_q + KT_W'(1)) == ktgt_q);
  assign emit_done = (mode_q == MODE_MAC) || last_row;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_row_idx <= '0;
      out_is_vec  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_row_idx <= out_row_idx_d;
      out_is_vec  <= out_is_vec_d;
      err         <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mode == MODE_MAC)
            state_d = (k_eff == KT_W'(1)) ? EMIT : ACCUM;
          else if (mode != MODE_BAD)
            state_d = EMIT;
        end
      end
      ACCUM: if (accept && mac_done) state_d = EMIT;
      EMIT:  if (out_fire && emit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; the first beat is loaded on the accepting edge.
  always_comb begin
    out_valid_d   = out_valid;
    out_data_d    = out_data;
    out_row_idx_d = out_row_idx;
    out_is_vec_d  = out_is_vec;
    err_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mode == MODE_BAD) begin
            err_d = 1'b1;
          end else if (mode != MODE_MAC) begin
            out_valid_d   = 1'b1;
            out_data_d    = tile_row(in_tile, '0);
            out_row_idx_d = '0;
            out_is_vec_d  = 1'b0;
          end else if (k_eff == KT_W'(1)) begin
            out_valid_d   = 1'b1;
            out_data_d    = rowsum_v;
            out_row_idx_d = '0;
            out_is_vec_d  = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept && mac_done) begin
          out_valid_d   = 1'b1;
          out_data_d    = accsum_v;
          out_row_idx_d = '0;
          out_is_vec_d  = 1'b1;
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (emit_done) begin
            out_valid_d = 1'b0;
          end else begin
            out_data_d    = tile_row(buf_q, row_q + RW'(1));
            out_row_idx_d = row_q + RW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= '0;
      ktgt_q <= '0;
      kcnt_q <= '0;
      acc_q  <= '0;
      buf_q  <= '0;
      row_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= mode;
            ktgt_q <= k_eff;
            if (mode == MODE_MAC) begin
              acc_q  <= rowsum_v;
              kcnt_q <= KT_W'(1);
            end else if (mode != MODE_BAD) begin
              buf_q <= in_tile;
              row_q <= '0;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q  <= accsum_v;
            kcnt_q <= kcnt_q + KT_W'(1);
          end
        end
        EMIT: if (out_fire && !emit_done) row_q <= row_q + RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_result_collector.sv
// tb/tb_tile_result_collector.sv - directed and randomized checks of tile_result_collector
module tb_tile_result_collector;
  localparam int T  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int TW = T * T * DW;
  localparam int VW = T * AW;

  typedef logic [TW-1:0] tile_t;
  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t       data;
    logic [1:0] idx;
    logic       vec;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    mode = '0;
  logic [KW-1:0] k_tiles = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  tile_t         in_tile = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  vec_t          out_data;
  logic [1:0]    out_row_idx;
  logic          out_is_vec;
  logic          err;

  int     tests = 0;
  int     fails = 0;
  beat_t  exp_q[$];
  logic   rdy_pat[$];
  bit     rand_rdy = 1'b0;
  longint msum[T];

  always #5 clk = ~clk;

  tile_result_collector #(.TILE_SIZE(T), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KT_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .k_tiles(k_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .in_tile(in_tile),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_idx(out_row_idx), .out_is_vec(out_is_vec), .err(err)
  );

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint el(input tile_t t, input int i, input int j);
    logic signed [DW-1:0] e;
    e = t[(i*T+j)*DW +: DW];
    return longint'(e);
  endfunction

  // kind 0: every element v; kind 1: row i holds i+1; kind 2: element 10*i+j
  function automatic tile_t pattern(input int kind, input longint v);
    tile_t  t;
    longint x;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) begin
        x = (kind == 0) ? v : (kind == 1) ? longint'(i + 1) : longint'(10 * i + j);
        t[(i*T+j)*DW +: DW] = x[DW-1:0];
      end
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int e = 0; e < T * T; e++) begin
      case ($urandom_range(0, 7))
        0:       t[e*DW +: DW] = 16'h8000;
        1:       t[e*DW +: DW] = 16'h7fff;
        default: t[e*DW +: DW] = 16'($urandom);
      endcase
    end
    return t;
  endfunction

  function automatic vec_t vec4(input longint a, input longint b, input longint c, input longint d);
    vec_t v;
    v[0*AW +: AW] = a[AW-1:0];
    v[1*AW +: AW] = b[AW-1:0];
    v[2*AW +: AW] = c[AW-1:0];
    v[3*AW +: AW] = d[AW-1:0];
    return v;
  endfunction

  task automatic push_beat(input vec_t d, input logic [1:0] idx, input logic vec);
    beat_t b;
    b.data = d;
    b.idx  = idx;
    b.vec  = vec;
    exp_q.push_back(b);
  endtask

  task automatic mac_clear();
    for (int i = 0; i < T; i++) msum[i] = 0;
  endtask

  task automatic mac_add(input tile_t t);
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++) msum[i] += el(t, i, j);
  endtask

  task automatic push_rows(input tile_t t);
    for (int r = 0; r < T; r++)
      push_beat(vec4(el(t, r, 0), el(t, r, 1), el(t, r, 2), el(t, r, 3)), 2'(r), 1'b0);
  endtask

  // Called and returns at posedge+1; the tile is held until the collector takes it.
  task automatic send_tile(input logic [2:0] m, input logic [KW-1:0] k, input tile_t t, input int gap);
    bit done;
    int budget;
    repeat (gap) begin @(posedge clk); #1; end
    mode = m; k_tiles = k; in_tile = t; in_valid = 1'b1;
    done = 1'b0;
    budget = 0;
    while (!done && budget < 300) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    mode = 3'($urandom);
    k_tiles = KW'($urandom);
    in_tile = rand_tile();
    check("accept_timeout", vec_t'(done), vec_t'(1));
  endtask

  task automatic expect_latency(input string tag);
    @(negedge clk);
    check(tag, vec_t'(out_valid), vec_t'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    check({tag, "_drained"}, vec_t'(exp_q.size() == 0 && !out_valid), vec_t'(1));
    check({tag, "_in_ready"}, vec_t'(in_ready), vec_t'(1));
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
    else if (rand_rdy)      out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b1;
  end

  logic       prev_stall = 1'b0;
  vec_t       prev_data;
  logic [1:0] prev_idx;
  logic       prev_vec;
  beat_t      mb;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", vec_t'(out_valid), vec_t'(1));
        check("stall_data", out_data, prev_data);
        check("stall_idx", vec_t'(out_row_idx), vec_t'(prev_idx));
        check("stall_vec", vec_t'(out_is_vec), vec_t'(prev_vec));
      end
      if (out_valid) begin
        check("in_ready_low_in_emit", vec_t'(in_ready), vec_t'(0));
        check("valid_has_expect", vec_t'(exp_q.size() != 0), vec_t'(1));
        if (out_ready && exp_q.size() != 0) begin
          mb = exp_q.pop_front();
          check("beat_data", out_data, mb.data);
          check("beat_idx", vec_t'(out_row_idx), vec_t'(mb.idx));
          check("beat_vec", vec_t'(out_is_vec), vec_t'(mb.vec));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_row_idx;
      prev_vec   = out_is_vec;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tile_t t;
    int    sel;
    int    keff;
    int    budget;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", vec_t'(out_valid), vec_t'(0));
    check("rst_out_data", out_data, vec_t'(0));
    check("rst_row_idx", vec_t'(out_row_idx), vec_t'(0));
    check("rst_is_vec", vec_t'(out_is_vec), vec_t'(0));
    check("rst_err", vec_t'(err), vec_t'(0));
    check("rst_in_ready", vec_t'(in_ready), vec_t'(1));
    @(posedge clk); #1;

    send_tile(3'b000, 8'd1, pattern(1, 0), 0);
    push_beat(vec4(4, 8, 12, 16), 2'd0, 1'b1);
    expect_latency("mac_k1_latency");
    drain("mac_k1");

    send_tile(3'b000, 8'd3, pattern(0, 1), 0);
    send_tile(3'b000, 8'd3, pattern(0, 2), 2);
    send_tile(3'b000, 8'd3, pattern(0, -3), 3);
    push_beat(vec4(0, 0, 0, 0), 2'd0, 1'b1);
    expect_latency("mac_k3_latency");
    drain("mac_k3");

    send_tile(3'b000, 8'd0, pattern(0, -32768), 1);
    push_beat(vec4(-131072, -131072, -131072, -131072), 2'd0, 1'b1);
    expect_latency("mac_k0_latency");
    drain("mac_k0");

    send_tile(3'b000, 8'd2, pattern(0, -32768), 0);
    send_tile(3'b000, 8'd2, pattern(0, -32768), 1);
    push_beat(vec4(-262144, -262144, -262144, -262144), 2'd0, 1'b1);
    expect_latency("mac_k2_latency");
    drain("mac_k2");

    send_tile(3'b001, 8'd0, pattern(2, 0), 0);
    for (int r = 0; r < T; r++) push_beat(vec4(10*r, 10*r+1, 10*r+2, 10*r+3), 2'(r), 1'b0);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    expect_latency("rows_latency");
    drain("rows_stall");

    mac_clear();
    t = rand_tile(); mac_add(t);
    send_tile(3'b000, 8'd2, t, 0);
    t = rand_tile(); mac_add(t);
    send_tile(3'b010, 8'd7, t, 1);
    push_beat(vec4(msum[0], msum[1], msum[2], msum[3]), 2'd0, 1'b1);
    expect_latency("mode_change_latency");
    drain("mode_change");

    send_tile(3'b111, 8'd1, rand_tile(), 0);
    @(negedge clk);
    check("err_pulse", vec_t'(err), vec_t'(1));
    check("err_no_valid", vec_t'(out_valid), vec_t'(0));
    check("err_in_ready", vec_t'(in_ready), vec_t'(1));
    @(negedge clk);
    check("err_one_cycle", vec_t'(err), vec_t'(0));
    check("err_in_ready_after", vec_t'(in_ready), vec_t'(1));
    @(posedge clk); #1;
    t = rand_tile();
    send_tile(3'b011, 8'd1, t, 0);
    push_rows(t);
    expect_latency("after_err_latency");
    drain("after_err");

    t = rand_tile();
    send_tile(3'b010, 8'd1, t, 0);
    push_rows(t);
    budget = 0;
    while (exp_q.size() > 2 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("reset_reached_row2", vec_t'(exp_q.size()), vec_t'(2));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_valid", vec_t'(out_valid), vec_t'(0));
    check("midreset_in_ready", vec_t'(in_ready), vec_t'(1));
    check("midreset_data", out_data, vec_t'(0));
    @(posedge clk); #1;
    send_tile(3'b000, 8'd1, pattern(0, 1), 0);
    push_beat(vec4(4, 4, 4, 4), 2'd0, 1'b1);
    expect_latency("post_reset_latency");
    drain("post_reset_mac");

    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 7);
      if (sel <= 2) begin
        k_tiles = KW'($urandom_range(0, 3));
        keff = (k_tiles == 0) ? 1 : int'(k_tiles);
        mac_clear();
        for (int m = 0; m < keff; m++) begin
          t = rand_tile();
          mac_add(t);
          send_tile((m == 0) ? 3'b000 : 3'($urandom), (m == 0) ? k_tiles : KW'($urandom), t,
                    $urandom_range(0, 2));
        end
        push_beat(vec4(msum[0], msum[1], msum[2], msum[3]), 2'd0, 1'b1);
        expect_latency("rand_mac_latency");
      end else if (sel <= 6) begin
        t = rand_tile();
        send_tile(3'($urandom_range(1, 6)), KW'($urandom), t, $urandom_range(0, 2));
        push_rows(t);
        expect_latency("rand_rows_latency");
      end else begin
        send_tile(3'b111, KW'($urandom), rand_tile(), $urandom_range(0, 2));
        @(negedge clk);
        check("rand_err_pulse", vec_t'(err), vec_t'(1));
        check("rand_err_no_valid", vec_t'(out_valid), vec_t'(0));
        @(negedge clk);
        check("rand_err_clear", vec_t'(err), vec_t'(0));
        @(posedge clk); #1;
      end
      drain("rand_op");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
